// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the fetch port and the data port.
// Optional macro MEMARB_FAIR_EN adds a starve counter so fetch cannot be locked out forever.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_amp,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,

    output logic              stall_i,
    output logic              stall_d,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              grant_d
);

    if (DATA_W != 32 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadParam
        $error("mem_arbiter: DATA_W must be 32 and STARVE_LIMIT must lie in 1..15");
    end

    localparam logic [ADDR_W-1:0] WordMask = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRespI = 2'd1,
        StRespD = 2'd2
    } state_e;

    state_e stateQ, stateD;
    logic   grantDQ, grantDD;
    logic   pickData;
    logic   pickFetch;

`ifdef MEMARB_FAIR_EN
    logic [3:0] starveQ, starveD;
    logic       starved;

    // Fetch has waited through STARVE_LIMIT data grants: it takes the next slot.
    assign starved  = i_req && (starveQ == 4'(STARVE_LIMIT));
    assign pickData = d_req && !starved;
`else
    assign pickData = d_req;
`endif

    assign pickFetch = i_req && !pickData;

    always_comb begin
        stateD    = stateQ;
        grantDD   = grantDQ;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        i_valid   = 1'b0;
        i_rdata   = '0;
        d_valid   = 1'b0;
        d_rdata   = '0;

        unique case (stateQ)
            StIdle: begin
                if (pickData) begin
                    mem_en    = 1'b1;
                    mem_we    = d_we ? d_amp : 4'b0000;
                    mem_addr  = d_addr & WordMask;
                    mem_wdata = d_wdata;
                    grantDD   = 1'b1;
                    stateD    = StRespD;
                end else if (pickFetch) begin
                    mem_en    = 1'b1;
                    mem_addr  = i_addr & WordMask;
                    grantDD   = 1'b0;
                    stateD    = StRespI;
                end
            end
            StRespI: begin
                i_valid = 1'b1;
                i_rdata = mem_rdata;
                stateD  = StIdle;
            end
            StRespD: begin
                d_valid = 1'b1;
                d_rdata = mem_rdata;
                stateD  = StIdle;
            end
            default: stateD = StIdle;
        endcase

        // Reset discards any outstanding response and blocks new accesses.
        if (reset) begin
            mem_en    = 1'b0;
            mem_we    = 4'b0000;
            mem_addr  = '0;
            mem_wdata = '0;
            i_valid   = 1'b0;
            i_rdata   = '0;
            d_valid   = 1'b0;
            d_rdata   = '0;
        end
    end

    assign stall_i = i_req & ~i_valid;
    assign stall_d = d_req & ~d_valid;
    assign grant_d = grantDQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= StIdle;
            grantDQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            grantDQ <= grantDD;
        end
    end

`ifdef MEMARB_FAIR_EN
    always_comb begin
        starveD = starveQ;
        if (stateQ == StIdle) begin
            if (!i_req) begin
                starveD = 4'd0;
            end else if (pickData) begin
                starveD = starveQ + 4'd1;
            end else begin
                starveD = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starveQ <= 4'd0;
        end else begin
            starveQ <= starveD;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts each memory
// issue and response; a separate monitor compares them against the DUT every cycle.
module tb_mem_arbiter;

    localparam int Limit  = 4;
    localparam int MaxCyc = 4000;
    localparam int RandLo = 80;
    localparam int RandHi = 1500;

    typedef struct packed {
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } issue_t;

    typedef struct packed {
        int          cyc;
        logic        isData;
        logic        isStore;
        logic [31:0] data;
    } resp_t;

    typedef struct packed {
        int          start;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  amp;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_amp;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_valid, d_valid, stall_i, stall_d, mem_en, grant_d;
    logic [3:0]  mem_we;

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (Limit)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_valid   (i_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_amp     (d_amp),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .stall_i   (stall_i),
        .stall_d   (stall_d),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .grant_d   (grant_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int k);
        if (k == 4) return 32'h0000_0013;
        return 32'h5A00_0000 ^ (k * 32'h0001_0307);
    endfunction

    // Physical RAM hanging off the DUT's memory bus.
    logic        initRam;
    logic [31:0] ram [128];
    logic [31:0] ramRdata;
    assign mem_rdata = ramRdata;

    always @(posedge clk) begin
        if (initRam) begin
            for (int k = 0; k < 128; k++) ram[k] <= initWord(k);
        end else if (mem_en) begin
            ramRdata <= ram[mem_addr[8:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Scoreboard state
    issue_t issueQ[$];
    resp_t  respQ[$];
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    bit     started  = 0;
    bit     gKnown   = 0;
    logic   expGrantD = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares what the DUT presents against the model's predictions.
    initial begin
        issue_t ie;
        resp_t  re;
        logic   expIV, expDV;
        forever begin
            @(negedge clk);
            if (started) begin
                expIV = 1'b0;
                expDV = 1'b0;
                if (issueQ.size() != 0 && issueQ[0].cyc == cyc) begin
                    ie = issueQ.pop_front();
                    chk("mem_en", 32'(mem_en), 32'd1);
                    chk("mem_addr", mem_addr, ie.addr);
                    chk("mem_we", 32'(mem_we), 32'(ie.we));
                    chk("mem_wdata", mem_wdata, ie.wdata);
                end else begin
                    chk("mem_en_quiet", 32'(mem_en), 32'd0);
                    chk("mem_we_quiet", 32'(mem_we), 32'd0);
                end
                if (respQ.size() != 0 && respQ[0].cyc == cyc) begin
                    re = respQ.pop_front();
                    expIV = !re.isData;
                    expDV = re.isData;
                    if (!re.isData) chk("i_rdata", i_rdata, re.data);
                    else if (!re.isStore) chk("d_rdata", d_rdata, re.data);
                end
                chk("i_valid", 32'(i_valid), 32'(expIV));
                chk("d_valid", 32'(d_valid), 32'(expDV));
                chk("stall_i", 32'(stall_i), 32'(i_req & ~expIV));
                chk("stall_d", 32'(stall_d), 32'(d_req & ~expDV));
                if (gKnown) chk("grant_d", 32'(grant_d), 32'(expGrantD));
            end
        end
    end

    function automatic logic [3:0] pickAmp(input int r);
        case (r)
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            3: return 4'b1000;
            4: return 4'b0011;
            5: return 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic cmd_t mkCmd(input int start, input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] amp);
        cmd_t c;
        c.start = start;
        c.we    = we;
        c.addr  = addr;
        c.wdata = wdata;
        c.amp   = amp;
        return c;
    endfunction

    // Stimulus plus transaction-level reference model.
    initial begin
        cmd_t        iQ[$];
        cmd_t        dQ[$];
        cmd_t        cmd;
        logic [31:0] refMem [128];
        bit          iActive, dActive, rstNow, armRst, doneAll;
        int          curResp, lastResp, starve, idx;
        logic        grantNow, gKnownNext;
        logic [31:0] rd;
        issue_t      ie;
        resp_t       re;

        reset = 1'b1; initRam = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_amp = '0;
        for (int k = 0; k < 128; k++) refMem[k] = initWord(k);

        // Directed: store byte during reset, fetch-only, read-back, contention, starvation.
        dQ.push_back(mkCmd(0, 1'b1, 32'h0000_0103, 32'hAB00_0000, 4'b1000));
        iQ.push_back(mkCmd(8, 1'b0, 32'h0000_0010, '0, '0));
        dQ.push_back(mkCmd(12, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'b1111));
        iQ.push_back(mkCmd(20, 1'b0, 32'h0000_0040, '0, '0));
        dQ.push_back(mkCmd(20, 1'b0, 32'h0000_0046, '0, 4'b0011));
        iQ.push_back(mkCmd(30, 1'b0, 32'h0000_0080, '0, '0));
        for (int k = 0; k < 10; k++) dQ.push_back(mkCmd(30, 1'b0, 32'(k * 8), '0, '0));
        iQ.push_back(mkCmd(34, 1'b0, 32'h0000_0084, '0, '0));
        dQ.push_back(mkCmd(64, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111));

        iActive = 0; dActive = 0; armRst = 0; doneAll = 0;
        curResp = 0; lastResp = 0; starve = 0;
        grantNow = 1'b0; gKnownNext = 0;

        for (int c = 0; c < MaxCyc && !doneAll; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            initRam = 1'b0;
            if (lastResp == 1) iActive = 0;
            if (lastResp == 2) dActive = 0;
            expGrantD = grantNow;
            gKnown    = gKnownNext;

            if (c == 64) armRst = 1;
            rstNow = (c < 3);
            if (armRst && curResp == 2) begin
                rstNow = 1;
                armRst = 0;
            end
            if (c >= RandLo && c < RandHi && $urandom_range(0, 99) == 0) rstNow = 1;

            if (c >= RandLo && c < RandHi) begin
                if (!iActive && iQ.size() == 0 && $urandom_range(0, 3) != 0)
                    iQ.push_back(mkCmd(c, 1'b0, 32'($urandom_range(0, 511)), '0, '0));
                if (!dActive && dQ.size() == 0 && $urandom_range(0, 3) != 0)
                    dQ.push_back(mkCmd(c, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)),
                                       $urandom, pickAmp($urandom_range(0, 6))));
            end
            if (!iActive && iQ.size() != 0 && iQ[0].start <= c) begin
                cmd = iQ.pop_front();
                i_addr = cmd.addr;
                iActive = 1;
            end
            if (!dActive && dQ.size() != 0 && dQ[0].start <= c) begin
                cmd = dQ.pop_front();
                d_we = cmd.we; d_addr = cmd.addr; d_wdata = cmd.wdata; d_amp = cmd.amp;
                dActive = 1;
            end
            reset = rstNow;
            i_req = iActive;
            d_req = dActive;
            started = 1;

            if (rstNow) begin
                if (curResp != 0) void'(respQ.pop_back());
                curResp    = 0;
                lastResp   = 0;
                starve     = 0;
                grantNow   = 1'b0;
                gKnownNext = 1;
            end else begin
                lastResp = curResp;
                if (curResp != 0) begin
                    curResp = 0;
                end else begin
`ifdef MEMARB_FAIR_EN
                    if (dActive && !(iActive && starve == Limit)) begin
`else
                    if (dActive) begin
`endif
                        idx        = int'(d_addr[8:2]);
                        rd         = refMem[idx];
                        ie.cyc     = c;
                        ie.addr    = {d_addr[31:2], 2'b00};
                        ie.we      = d_we ? d_amp : 4'b0000;
                        ie.wdata   = d_wdata;
                        issueQ.push_back(ie);
                        re.cyc     = c + 1;
                        re.isData  = 1'b1;
                        re.isStore = d_we;
                        re.data    = rd;
                        respQ.push_back(re);
                        for (int b = 0; b < 4; b++)
                            if (ie.we[b]) refMem[idx][8*b +: 8] = d_wdata[8*b +: 8];
                        starve   = iActive ? starve + 1 : 0;
                        grantNow = 1'b1;
                        curResp  = 2;
                    end else if (iActive) begin
                        idx        = int'(i_addr[8:2]);
                        ie.cyc     = c;
                        ie.addr    = {i_addr[31:2], 2'b00};
                        ie.we      = 4'b0000;
                        ie.wdata   = '0;
                        issueQ.push_back(ie);
                        re.cyc     = c + 1;
                        re.isData  = 1'b0;
                        re.isStore = 1'b0;
                        re.data    = refMem[idx];
                        respQ.push_back(re);
                        starve   = 0;
                        grantNow = 1'b0;
                        curResp  = 1;
                    end else begin
                        starve = 0;
                    end
                end
            end

            if (c > RandHi && !iActive && !dActive && iQ.size() == 0 && dQ.size() == 0 &&
                curResp == 0 && !armRst)
                doneAll = 1;
        end

        @(negedge clk);
        #1;
        checks++;
        if (!doneAll) begin
            failures++;
            $display("FAIL drain_timeout got=not_idle want=idle_within_%0d_cycles", MaxCyc);
        end
        checks++;
        if (issueQ.size() != 0 || respQ.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations got=%0d/%0d want=0/0",
                     issueQ.size(), respQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
